// File: rtl/rf_pkg.sv
// Shared types and sizing for the register-file write arbiter.
package rf_pkg;
  localparam int RF_AW   = 3;
  localparam int RF_DW   = 8;
  localparam int RF_NREG = 8;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef enum logic {IDLE, INIT} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational grant, registered last-winner.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);
  // High when port B (req[1]) won most recently; reset so A wins first conflict.
  logic last_b;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_b ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      last_b <= 1'b1;
    else if (gnt != 2'b00)
      last_b <= gnt[1];
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between ALU and load writeback, and can
// sweep zeros through every register on InitStart.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW,
  parameter int NREG = RF_NREG
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ReqA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataA,
  output logic          GntA,
  input  logic          ReqB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataB,
  output logic          GntB,
  input  logic          InitStart,
  output logic          InitBusy,
  output logic          Wen,
  output logic [AW-1:0] Wd,
  output logic [DW-1:0] Wdat
);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG-1);

  arb_state_t  state, state_nxt;
  logic [AW:0] cnt;
  logic [1:0]  gnt;
  logic        arb_en;

  rr_arb2 u_arb (
    .Clk    (Clk),
    .Reset  (Reset),
    .req    ({ReqB, ReqA}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (InitStart) state_nxt = INIT;
      INIT:    if (cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // InitStart outranks both requesters in the cycle it arrives.
  always_comb begin
    arb_en   = (state == IDLE) && !InitStart;
    InitBusy = (state == INIT);
    GntA     = gnt[0];
    GntB     = gnt[1];
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      cnt <= '0;
    else if (state == INIT)
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Wen  <= 1'b0;
      Wd   <= '0;
      Wdat <= '0;
    end else if (state == INIT) begin
      Wen  <= 1'b1;
      Wd   <= cnt[AW-1:0];
      Wdat <= '0;
    end else if (gnt[0]) begin
      Wen  <= 1'b1;
      Wd   <= AddrA;
      Wdat <= DataA;
    end else if (gnt[1]) begin
      Wen  <= 1'b1;
      Wd   <= AddrB;
      Wdat <= DataB;
    end else begin
      Wen  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter with a write scoreboard.
module tb_rf_write_arbiter;
  import rf_pkg::*;
  localparam int NREG = RF_NREG;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ReqA = 1'b0, ReqB = 1'b0, InitStart = 1'b0;
  logic [2:0] AddrA = '0, AddrB = '0;
  logic [7:0] DataA = '0, DataB = '0;
  logic       GntA, GntB, InitBusy, Wen;
  logic [2:0] Wd;
  logic [7:0] Wdat;

  int checks = 0;
  int failures = 0;

  logic [7:0] rf     [8];
  logic [7:0] exp_rf [8];

  typedef struct {
    bit         en;
    bit         all;
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t q[$];

  // Reference state: who won last, and how many zeroing writes remain.
  bit m_last_b;
  int m_left;

  rf_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .GntA(GntA),
    .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .GntB(GntB),
    .InitStart(InitStart), .InitBusy(InitBusy),
    .Wen(Wen), .Wd(Wd), .Wdat(Wdat)
  );

  always #5 Clk = ~Clk;

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]     = 8'h00;
      exp_rf[i] = 8'h00;
    end
  end

  always @(posedge Clk) if (Wen) rf[Wd] <= Wdat;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, describing what the write port must show.
  always @(negedge Clk) begin
    wr_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wen", int'(Wen), int'(e.en));
      if (e.en || e.all) begin
        chk("wd", int'(Wd), int'(e.addr));
        chk("wdat", int'(Wdat), int'(e.data));
      end
    end
  end

  // Reference model: evaluated mid-cycle once inputs and grants have settled.
  always @(negedge Clk) begin
    wr_t w;
    bit  wa, wb;
    #1;
    w.en = 0; w.all = 0; w.addr = '0; w.data = '0;
    if (Reset) begin
      w.all    = 1;
      m_last_b = 1;
      m_left   = 0;
    end else if (m_left > 0) begin
      chk("gnta_init", int'(GntA), 0);
      chk("gntb_init", int'(GntB), 0);
      chk("busy_init", int'(InitBusy), 1);
      w.en   = 1;
      w.addr = 3'(NREG - m_left);
      w.data = 8'h00;
      m_left--;
    end else begin
      chk("busy_idle", int'(InitBusy), 0);
      if (InitStart) begin
        chk("gnta_start", int'(GntA), 0);
        chk("gntb_start", int'(GntB), 0);
        m_left = NREG;
      end else begin
        wa = ReqA && (!ReqB || m_last_b);
        wb = ReqB && !wa;
        chk("gnta", int'(GntA), int'(wa));
        chk("gntb", int'(GntB), int'(wb));
        if (wa) begin
          w.en = 1; w.addr = AddrA; w.data = DataA; m_last_b = 0;
        end else if (wb) begin
          w.en = 1; w.addr = AddrB; w.data = DataB; m_last_b = 1;
        end
      end
    end
    if (w.en) exp_rf[w.addr] = w.data;
    q.push_back(w);
  end

  task automatic send_a(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    ReqA = 1'b1; AddrA = a; DataA = d;
    do begin @(negedge Clk); n++; end while (!GntA && n < 200);
    if (!GntA) chk("gnta_timeout", 0, 1);
    @(posedge Clk); #1;
    ReqA = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    ReqB = 1'b1; AddrB = a; DataB = d;
    do begin @(negedge Clk); n++; end while (!GntB && n < 200);
    if (!GntB) chk("gntb_timeout", 0, 1);
    @(posedge Clk); #1;
    ReqB = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic do_init();
    InitStart = 1'b1;
    @(posedge Clk); #1;
    InitStart = 1'b0;
  endtask

  task automatic preload_ff();
    for (int i = 0; i < 8; i++) send_a(3'(i), 8'hFF);
    idle(3);
  endtask

  task automatic check_regs();
    idle(3);
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), int'(rf[i]), int'(exp_rf[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    idle(3);
    Reset = 1'b0;
    idle(1);

    send_a(3'd3, 8'h5A);
    idle(3);
    chk("rf3_first", int'(rf[3]), 8'h5A);

    fork
      send_a(3'd1, 8'h11);
      send_b(3'd2, 8'h22);
    join
    idle(3);
    chk("rf1_both", int'(rf[1]), 8'h11);
    chk("rf2_both", int'(rf[2]), 8'h22);

    fork
      for (int i = 0; i < 4; i++) send_a(3'(i), 8'($urandom));
      for (int j = 0; j < 4; j++) send_b(3'(4 + j), 8'($urandom));
    join
    check_regs();

    preload_ff();
    do_init();
    idle(NREG + 2);
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d_zero", i), int'(rf[i]), 0);

    fork
      do_init();
      send_a(3'd5, 8'h77);
    join
    idle(3);
    chk("rf5_after_init", int'(rf[5]), 8'h77);

    do_init();
    idle(3);
    do_init();
    idle(NREG + 2);
    check_regs();

    preload_ff();
    do_init();
    idle(3);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) chk($sformatf("rf%0d_abort_lo", i), int'(rf[i]), 0);
    for (int i = 4; i < 8; i++) chk($sformatf("rf%0d_abort_hi", i), int'(rf[i]), 8'hFF);

    fork
      for (int i = 0; i < 25; i++) begin
        idle($urandom_range(0, 3));
        send_a(3'($urandom), 8'($urandom));
      end
      for (int j = 0; j < 25; j++) begin
        idle($urandom_range(0, 3));
        send_b(3'($urandom), 8'($urandom));
      end
      for (int k = 0; k < 3; k++) begin
        idle($urandom_range(10, 40));
        do_init();
      end
    join
    idle(NREG + 2);
    check_regs();

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port (Wen/Wd/Wdat) of the 8x8 register file.
- Shares that port between two requesters: port A (ALU writeback) and port B (load writeback).
- Round-robin arbitration when both request in the same cycle.
- Built-in init sequencer zeroes all registers, one per cycle, on command. Used for soft-restart without pulsing the regfile Reset.

Parameters:
- DW, 8, data width of a register-file entry.
- AW, 3, register address width.
- NREG, 8, registers cleared by the init sequence (NREG <= 2**AW).

Ports:
- Clk  input  1  clock; all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqA  input  1  port A write request; held until GntA.
- AddrA  input  AW  port A destination register.
- DataA  input  DW  port A write data.
- GntA  output  1  port A accepted this cycle (combinational).
- ReqB  input  1  port B write request; held until GntB.
- AddrB  input  AW  port B destination register.
- DataB  input  DW  port B write data.
- GntB  output  1  port B accepted this cycle (combinational).
- InitStart  input  1  one-cycle pulse: begin clearing the register file.
- InitBusy  output  1  init sequence in progress.
- Wen  output  1  registered write enable to the regfile.
- Wd  output  AW  registered write address to the regfile.
- Wdat  output  DW  registered write data to the regfile.

Behaviour:
- Reset (synchronous, active-high; clock Clk):
  - Wen=0, Wd=0, Wdat=0, InitBusy=0, state=IDLE, init counter=0.
  - LastGnt=B, so A wins the first conflict.
  - Reset mid-init aborts the sequence; the next cycle is IDLE.
- FSM states: IDLE, INIT.
  - IDLE -> INIT on InitStart=1.
  - INIT -> IDLE after the write to register NREG-1 is issued.
- IDLE arbitration (combinational grant, registered write):
  - Only ReqA: GntA=1.
  - Only ReqB: GntB=1.
  - Both: grant the port not in LastGnt. LastGnt updates to the winner on every grant.
  - At most one of GntA/GntB is high in any cycle.
  - On a grant at edge N, Wen=1 with the winner's Addr/Data during cycle N+1.
  - No grant: Wen=0 next cycle. Wd/Wdat hold their previous value (don't-care).
  - The losing requester keeps Req asserted and is granted next cycle unless preempted by InitStart.
  - Latency from grant to write visible in the regfile: 2 edges (arbiter flop, then regfile flop).
- InitStart in IDLE has priority over ReqA/ReqB that cycle: GntA=GntB=0.
  - The next cycle enters INIT with InitBusy=1.
- INIT:
  - GntA=GntB=0; requesters stall.
  - Each cycle issue Wen=1, Wd=counter, Wdat=0; counter increments.
  - After counter=NREG-1 is issued: counter returns to 0, state returns to IDLE, InitBusy=0 on the following cycle.
  - Total: exactly NREG consecutive Wen cycles.
- InitStart while in INIT is ignored; the sequence does not restart.
- The counter is AW+1 bits wide, so no wrap ambiguity when NREG == 2**AW.
- Both requesters targeting the same address: no special handling. Writes are serialized in grant order, so the last granted wins.
- Req deasserted before its grant: legal, no write occurs.
- Addr/Data are sampled only in the grant cycle.

Decomposition:
- Shared package rf_pkg:
  - typedef rf_addr_t = logic[AW-1:0];
  - typedef rf_data_t = logic[DW-1:0];
  - enum arb_state_t {IDLE, INIT};
  - localparam RF_NREG = 8.
- One sub-module, rr_arb2: 2-way round-robin grant logic plus LastGnt flop. Inputs req[1:0] and enable; outputs gnt[1:0].
- FSM, init counter and output registers stay in rf_write_arbiter.

Test Plan:
- After Reset, ReqA=1 AddrA=3 DataA=0x5A for one grant: GntA=1 in cycle 0; next cycle Wen=1 Wd=3 Wdat=0x5A; regfile reg 3 reads 0x5A thereafter.
- ReqA (r1, 0x11) and ReqB (r2, 0x22) both held from cycle 0:
  - cycle 0 grants A;
  - cycle 1 grants B;
  - Wen cycles 1 and 2 write r1=0x11, then r2=0x22.
- Both held for 4 grants each (new data per grant): grants alternate A,B,A,B,...; never two consecutive grants to one port while the other requests.
- Preload r0..r7 with 0xFF, then InitStart=1:
  - InitBusy=1 for 8 cycles;
  - Wd=0..7 with Wdat=0, GntA=GntB=0 throughout;
  - afterwards all registers read 0x00.
- ReqA held during init: GntA first asserts the cycle after InitBusy falls; the write lands after the init writes.
- Reset asserted when the init counter is 4: Wen=0 the next cycle, InitBusy=0; registers 4..7 keep their 0xFF.
- Optional edge case, InitStart pulsed again mid-init: still exactly 8 Wen cycles.
